// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types for the instruction register stack and the
//               execution stage behind it. Holds the opcode, operand and
//               instruction-word types, the execution FSM state type, the
//               signed result type and the single-cycle ALU helper.
// Revision    : 1.0  initial release
// ============================================================================
package instr_register_pkg;

    localparam int IR_ADDR_W = 5;
    localparam int IR_OP_W   = 32;
    localparam int IR_RES_W  = 2 * IR_OP_W;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [IR_OP_W-1:0]  operand_t;
    typedef logic signed [IR_RES_W-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } iw_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DIVW  = 3'd3,
        S_RESP  = 3'd4,
        S_DONE  = 3'd5
    } exec_state_t;

    // DIV and MOD go through the sequential divider; everything else is
    // resolved in a single EXEC cycle.
    function automatic logic is_div_op(input opcode_t opc);
        return (opc == DIV) || (opc == MOD);
    endfunction

    // Single-cycle opcodes. Operands are sign-extended to the result width
    // first so ADD/SUB cannot overflow and MULT yields the full product.
    function automatic result_t exec_single(input opcode_t  opc,
                                            input operand_t a,
                                            input operand_t b);
        result_t ea;
        result_t eb;
        result_t r;
        ea = result_t'(a);
        eb = result_t'(b);
        case (opc)
            PASSA:   r = ea;
            PASSB:   r = eb;
            ADD:     r = ea + eb;
            SUB:     r = ea - eb;
            MULT:    r = ea * eb;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/instr_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : instr_div_seq
// Description : Sequential signed divider. Restoring division on operand
//               magnitudes, one quotient bit per clock, fixed W-cycle latency
//               from the start pulse to the done pulse. Signs are applied on
//               the way out: quotient truncates toward zero, remainder takes
//               the sign of the dividend.
// Ports       : clk, reset (async, active high)
//               start     - 1-cycle launch pulse, samples dividend/divisor
//               dividend  - signed W-bit numerator
//               divisor   - signed W-bit denominator (must be non-zero)
//               done      - 1-cycle pulse, quotient/remainder valid with it
//               quotient  - signed W+1 bits so MIN/-1 = +2**(W-1) fits
//               remainder - signed W bits
// Revision    : 1.0  initial release
// ============================================================================
module instr_div_seq #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic                done,
    output logic signed [W:0]   quotient,
    output logic signed [W-1:0] remainder
);

    localparam int CNT_W = $clog2(W) + 1;

    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_dvs_mag;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_run;
    logic [CNT_W-1:0] r_cnt;

    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [2*W-1:0]   w_first_step;
    logic [2*W-1:0]   w_next_step;
    logic [W:0]       w_q_ext;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. Returns {rem, quo}.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] quo,
                                                input logic [W-1:0] dvs);
        logic [W:0] shifted;
        logic [W:0] trial;
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[W]) begin
            return {shifted[W-1:0], quo[W-2:0], 1'b0};
        end
        return {trial[W-1:0], quo[W-2:0], 1'b1};
    endfunction

    // Two's-complement magnitude; MIN_INT maps to 2**(W-1) as unsigned.
    assign w_a_mag = dividend[W-1] ? (~dividend + 1'b1) : dividend;
    assign w_b_mag = divisor[W-1]  ? (~divisor  + 1'b1) : divisor;

    // The first step is taken in the launch cycle itself so that the final
    // step lands W-1 clocks later and done rises exactly W cycles after start.
    assign w_first_step = div_step('0, w_a_mag, w_b_mag);
    assign w_next_step  = div_step(r_rem, r_quo, r_dvs_mag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs_mag <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_run     <= 1'b0;
            r_cnt     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {r_rem, r_quo} <= w_first_step;
                r_dvs_mag      <= w_b_mag;
                r_q_neg        <= dividend[W-1] ^ divisor[W-1];
                r_r_neg        <= dividend[W-1];
                r_cnt          <= CNT_W'(W - 1);
                r_run          <= 1'b1;
            end else if (r_run) begin
                {r_rem, r_quo} <= w_next_step;
                r_cnt          <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_run <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    // Sign fix-up on the registered magnitudes.
    assign w_q_ext   = {1'b0, r_quo};
    assign quotient  = r_q_neg ? $signed(-w_q_ext) : $signed(w_q_ext);
    assign remainder = r_r_neg ? $signed(-r_rem)   : $signed(r_rem);

endmodule : instr_div_seq
`default_nettype wire

// File: rtl/instr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_exec_unit
// Description : Execution stage behind the instruction register stack. On
//               start it walks read_pointer over a run of locations, captures
//               each instruction word, executes it and hands one result per
//               instruction out over a valid/ready handshake.
// Ports       : clk, reset (async, active high)
//               start/start_addr/count   - run request, sampled in IDLE only
//               read_pointer             - address to the register stack
//               instruction_word         - word at read_pointer (comb.)
//               result/result_opc/result_addr/div_zero - result payload
//               result_valid/result_ready - output handshake
//               busy                     - run in progress
//               done                     - 1-cycle pulse at run completion
// Revision    : 1.0  initial release
// ============================================================================
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = IR_ADDR_W,
    parameter int OP_W   = IR_OP_W,
    parameter int RES_W  = IR_RES_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [ADDR_W:0]         count,
    output logic [ADDR_W-1:0]       read_pointer,
    input  iw_t                     instruction_word,
    output logic signed [RES_W-1:0] result,
    output opcode_t                 result_opc,
    output logic [ADDR_W-1:0]       result_addr,
    output logic                    div_zero,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy,
    output logic                    done
);

    exec_state_t               r_state;
    iw_t                       r_iw;
    logic [ADDR_W:0]           r_remaining;

    logic                      w_div_start;
    logic                      w_div_done;
    logic signed [OP_W:0]      w_div_quo;
    logic signed [OP_W-1:0]    w_div_rem;

    // Divider is launched from EXEC only for a real division; a zero divisor
    // is answered directly without ever starting it.
    assign w_div_start = (r_state == S_EXEC) && is_div_op(r_iw.opc) &&
                         (r_iw.op_b != '0);

    instr_div_seq #(
        .W (OP_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (r_iw.op_a),
        .divisor   (r_iw.op_b),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_iw         <= '0;
            r_remaining  <= '0;
            read_pointer <= '0;
            result       <= '0;
            result_opc   <= ZERO;
            result_addr  <= '0;
            div_zero     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        read_pointer <= start_addr;
                        r_remaining  <= count;
                        busy         <= 1'b1;
                        if (count != '0) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    r_iw        <= instruction_word;
                    r_remaining <= r_remaining - (ADDR_W+1)'(1);
                    r_state     <= S_EXEC;
                end

                S_EXEC: begin
                    // Payload tags can change here: valid is low until RESP.
                    result_opc  <= r_iw.opc;
                    result_addr <= read_pointer;
                    if (is_div_op(r_iw.opc)) begin
                        if (r_iw.op_b == '0) begin
                            result       <= '0;
                            div_zero     <= 1'b1;
                            result_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_DIVW;
                        end
                    end else begin
                        result       <= RES_W'(exec_single(r_iw.opc, r_iw.op_a, r_iw.op_b));
                        div_zero     <= 1'b0;
                        result_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_DIVW: begin
                    if (w_div_done) begin
                        result       <= (r_iw.opc == DIV) ? RES_W'(w_div_quo)
                                                          : RES_W'(w_div_rem);
                        div_zero     <= 1'b0;
                        result_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Payload is frozen until the consumer takes it.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        read_pointer <= read_pointer + ADDR_W'(1);
                        if (r_remaining != '0) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : instr_exec_unit
`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_exec_unit
// Description : Self-checking bench for instr_exec_unit. A register-stack
//               array feeds instruction_word; expected results come from a
//               plain-arithmetic model and are queued at start, and a monitor
//               compares every presented result against the queue head.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    localparam int AW      = IR_ADDR_W;
    localparam int DIV_LAT = 3 + IR_OP_W;

    typedef struct {
        longint        res;
        opcode_t       opc;
        logic [AW-1:0] addr;
        logic          dz;
    } exp_t;

    logic                       clk;
    logic                       reset;
    logic                       start;
    logic [AW-1:0]              start_addr;
    logic [AW:0]                count;
    logic [AW-1:0]              read_pointer;
    iw_t                        iw_bus;
    logic signed [IR_RES_W-1:0] result;
    opcode_t                    result_opc;
    logic [AW-1:0]              result_addr;
    logic                       div_zero;
    logic                       result_valid;
    logic                       result_ready;
    logic                       busy;
    logic                       done;

    iw_t  mem [2**AW];
    exp_t sb [$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    bit   rdy_auto  = 1'b0;

    assign iw_bus = mem[read_pointer];

    instr_exec_unit dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (iw_bus),
        .result           (result),
        .result_opc       (result_opc),
        .result_addr      (result_addr),
        .div_zero         (div_zero),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic iw_t mk(input opcode_t o, input int a, input int b);
        return '{opc: o, op_a: operand_t'(a), op_b: operand_t'(b)};
    endfunction

    // Reference: the arithmetic rules evaluated on 64-bit integers.
    function automatic exp_t model(input logic [AW-1:0] addr);
        exp_t   e;
        longint a;
        longint b;
        a      = longint'(mem[addr].op_a);
        b      = longint'(mem[addr].op_b);
        e.opc  = mem[addr].opc;
        e.addr = addr;
        e.dz   = 1'b0;
        e.res  = 0;
        case (e.opc)
            PASSA: e.res = a;
            PASSB: e.res = b;
            ADD:   e.res = a + b;
            SUB:   e.res = a - b;
            MULT:  e.res = a * b;
            DIV:   if (b == 0) e.dz = 1'b1; else e.res = a / b;
            MOD:   if (b == 0) e.dz = 1'b1; else e.res = a % b;
            default: e.res = 0;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(req));
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) done_seen++;
                if (result_valid) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got addr=%0d res=%0d, required no result",
                                 result_addr, result);
                    end else begin
                        e = sb[0];
                        if (result !== e.res || result_opc !== e.opc ||
                            result_addr !== e.addr || div_zero !== e.dz) begin
                            errors++;
                            $display("FAIL result: got res=%0d opc=%0d addr=%0d dz=%0b, required res=%0d opc=%0d addr=%0d dz=%0b",
                                     result, result_opc, result_addr, div_zero,
                                     e.res, e.opc, e.addr, e.dz);
                        end
                        if (result_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rdy_auto) result_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Queue the run's expected results, pulse start, and measure the cycles
    // until the first result_valid.
    task automatic run_start(input logic [AW-1:0] sa, input logic [AW:0] cnt,
                             input bit chk_lat, input string name);
        logic [AW-1:0] a;
        int            n;
        int            lat;
        a   = sa;
        lat = ((mem[sa].opc == DIV || mem[sa].opc == MOD) && mem[sa].op_b != 0) ? DIV_LAT : 3;
        for (int i = 0; i < int'(cnt); i++) begin
            sb.push_back(model(a));
            a = a + AW'(1);
        end
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        @(posedge clk);
        #1;
        n          = 1;
        start      = 1'b0;
        start_addr = AW'($urandom);
        count      = (AW+1)'($urandom);
        while (!result_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (chk_lat) chk(name, 64'(n), 64'(lat));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: got busy=%0b pending=%0d after timeout, required idle with 0 pending",
                     name, busy, sb.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_pointer"}, 64'(read_pointer), 64'(0));
        chk({tag, "_result"},       64'(result),       64'(0));
        chk({tag, "_result_opc"},   64'(result_opc),   64'(ZERO));
        chk({tag, "_result_addr"},  64'(result_addr),  64'(0));
        chk({tag, "_div_zero"},     64'(div_zero),     64'(0));
        chk({tag, "_result_valid"}, 64'(result_valid), 64'(0));
        chk({tag, "_busy"},         64'(busy),         64'(0));
        chk({tag, "_done"},         64'(done),         64'(0));
    endtask

    function automatic int rnd_operand();
        int s;
        s = int'($urandom_range(0, 7));
        if (s == 0) return int'(32'h8000_0000);
        if (s == 1) return -1;
        if (s == 2) return 0;
        if (s < 5)  return int'($urandom_range(0, 200)) - 100;
        return int'($urandom);
    endfunction

    initial begin
        int            d0;
        logic [AW-1:0] sa;
        logic [AW-1:0] a;
        logic [AW:0]   cnt;

        reset        = 1'b1;
        start        = 1'b0;
        start_addr   = '0;
        count        = '0;
        result_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;

        fork
            monitor();
            ready_driver();
            begin
                #900000;
                $display("FAIL watchdog: got no finish, required finish before time limit");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Short arithmetic run with a permanently ready consumer.
        mem[0] = mk(ADD, 5, -3);
        mem[1] = mk(SUB, -15, 15);
        mem[2] = mk(MULT, -7, 9);
        result_ready = 1'b1;
        d0 = done_seen;
        run_start(5'd0, 6'd3, 1'b1, "lat_single");
        wait_idle("idle_arith");
        chk("done_pulses_arith", 64'(done_seen - d0), 64'(1));

        // Division, modulo, divide-by-zero, MIN/-1 corner.
        mem[3] = mk(DIV, -15, 4);
        mem[4] = mk(MOD, -15, 4);
        mem[5] = mk(DIV, 9, 0);
        run_start(5'd3, 6'd3, 1'b1, "lat_div");
        wait_idle("idle_div");
        mem[6] = mk(DIV, int'(32'h8000_0000), -1);
        mem[7] = mk(MOD, int'(32'h8000_0000), -1);
        run_start(5'd6, 6'd2, 1'b1, "lat_minint");
        wait_idle("idle_minint");

        // Back-pressure: result must hold and read_pointer must not move.
        mem[10] = mk(PASSA, 11, 2);
        result_ready = 1'b0;
        run_start(5'd10, 6'd1, 1'b1, "lat_bp");
        for (int i = 0; i < 4; i++) begin
            chk("bp_read_pointer", 64'(read_pointer), 64'(10));
            chk("bp_result",       64'(result),       64'(11));
            @(posedge clk);
            #1;
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rp_after_accept",    64'(read_pointer), 64'(11));
        chk("bp_valid_after_accept", 64'(result_valid), 64'(0));
        wait_idle("idle_bp");

        // Address wrap with a random consumer.
        for (int i = 0; i < 4; i++) begin
            a = AW'(30 + i);
            mem[a] = mk(opcode_t'(3'($urandom_range(0, 5))), rnd_operand(), rnd_operand());
        end
        rdy_auto = 1'b1;
        run_start(5'd30, 6'd4, 1'b1, "lat_wrap");
        wait_idle("idle_wrap");
        chk("wrap_read_pointer_end", 64'(read_pointer), 64'(2));

        // Empty run.
        rdy_auto     = 1'b0;
        result_ready = 1'b1;
        d0           = done_seen;
        start        = 1'b1;
        start_addr   = 5'd7;
        count        = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("cnt0_done",  64'(done),         64'(1));
        chk("cnt0_valid", 64'(result_valid), 64'(0));
        chk("cnt0_rp",    64'(read_pointer), 64'(7));
        @(posedge clk);
        #1;
        chk("cnt0_done_drop", 64'(done), 64'(0));
        chk("cnt0_busy_drop", 64'(busy), 64'(0));

        // A start during a run must be ignored.
        for (int i = 12; i < 15; i++)
            mem[i] = mk(opcode_t'(3'($urandom_range(0, 5))), rnd_operand(), rnd_operand());
        d0 = done_seen;
        run_start(5'd12, 6'd3, 1'b1, "lat_busy");
        start      = 1'b1;
        start_addr = 5'd20;
        count      = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("idle_busy_start");
        chk("busy_start_done_pulses", 64'(done_seen - d0), 64'(1));
        chk("busy_start_rp_end",      64'(read_pointer),   64'(15));

        // Reset five cycles into a division.
        mem[16] = mk(DIV, 1000, 7);
        start      = 1'b1;
        start_addr = 5'd16;
        count      = 6'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("divw_busy_before_reset", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_start(5'd16, 6'd1, 1'b1, "lat_after_reset");
        wait_idle("idle_after_reset");

        // Randomized runs against the model.
        rdy_auto = 1'b1;
        for (int r = 0; r < 25; r++) begin
            sa  = AW'($urandom);
            cnt = (AW+1)'($urandom_range(1, 6));
            a   = sa;
            for (int i = 0; i < int'(cnt); i++) begin
                mem[a] = mk(opcode_t'(3'($urandom_range(0, 7))), rnd_operand(), rnd_operand());
                a = a + AW'(1);
            end
            run_start(sa, cnt, 1'b1, "lat_random");
            wait_idle("idle_random");
        end

        rdy_auto = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_exec_unit
`default_nettype wire
